// File: rtl/mult_seq_32.sv
// Sequential 32x32 unsigned shift-and-add multiplier built on a 32-bit
// carry-lookahead adder; one partial-product accumulation per clock.

module CLA_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] s,
  output logic        c_out,
  output logic        overflow
);

  logic [31:0] g, p, bc;
  logic [7:0]  gg, gp, grp_c;
  logic        carry;

  assign g = a & b;
  assign p = a ^ b;

  // Four-bit lookahead groups; group carries ripple through a local variable.
  for (genvar k = 0; k < 8; k++) begin : g_grp
    localparam int B = 4 * k;
    assign gg[k] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                 | (p[B+3] & p[B+2] & p[B+1] & g[B]);
    assign gp[k] = &p[B+3:B];
    assign bc[B]   = grp_c[k];
    assign bc[B+1] = g[B] | (p[B] & grp_c[k]);
    assign bc[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & grp_c[k]);
    assign bc[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                   | (p[B+2] & p[B+1] & p[B] & grp_c[k]);
  end

  always_comb begin
    carry = c_in;
    grp_c = '0;
    for (int k = 0; k < 8; k++) begin
      grp_c[k] = carry;
      carry    = gg[k] | (gp[k] & carry);
    end
    c_out = carry;
  end

  assign s        = p ^ bc;
  assign overflow = bc[31] ^ c_out;

endmodule

module mult_seq_32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [63:0] product,
  output logic        overflow
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  // acc[64] of the reference model is provably always zero, so it is not stored.
  logic [63:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] product_q, product_d;
  logic        overflow_q, overflow_d;

  logic [31:0] add_s;
  logic        add_c;

  CLA_32 u_cla (
    .a        (acc_q[63:32]),
    .b        (mcand_q),
    .c_in     (1'b0),
    .s        (add_s),
    .c_out    (add_c),
    .overflow ()
  );

  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    product_d  = product_q;
    overflow_d = overflow_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mcand_d = a;
          acc_d   = {32'd0, b};
          cnt_d   = 6'd0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // The adder carry lands in bit 63 after the shift, so nothing is lost.
        if (acc_q[0]) acc_d = {add_c, add_s, acc_q[31:1]};
        else          acc_d = {1'b0, acc_q[63:32], acc_q[31:1]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd31) begin
          state_d    = S_DONE;
          product_d  = acc_d;
          overflow_d = |acc_d[63:32];
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mcand_q    <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      product_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      product_q  <= product_d;
      overflow_q <= overflow_d;
    end
  end

  assign ready    = (state_q == S_IDLE);
  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign product  = product_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_mult_seq_32.sv
// Self-checking bench for mult_seq_32: vector table, corner sequences and a
// random regression, with a queue of expected results popped on each done.

module tb_mult_seq_32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a, b;
  logic        ready, busy, done, overflow;
  logic [63:0] product;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
    logic        ovf;
  } vec_t;

  vec_t exp_q[$];
  vec_t vecs[8];

  mult_seq_32 dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wait for done (sampled 1 time unit after each rising edge); returns edges seen.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 40);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_wait", {63'd0, ready}, 64'd1);
  endtask

  // Full operation through the scoreboard: push expectation, run, pop and compare.
  task automatic run_op(input logic [31:0] va, input logic [31:0] vb);
    vec_t e, got;
    int n;
    wait_ready();
    @(negedge clk);
    e.a = va; e.b = vb;
    e.prod = {32'd0, va} * {32'd0, vb};
    e.ovf = |e.prod[63:32];
    exp_q.push_back(e);
    start = 1'b1; a = va; b = vb;
    @(posedge clk); #1;
    start = 1'b0;
    chk("accept_busy_ready", {62'd0, busy, ready}, 64'd2);
    wait_done(n);
    chk("latency", 64'(n), 64'd32);
    if (exp_q.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      got = exp_q.pop_front();
      chk("product", product, got.prod);
      chk("overflow", {63'd0, overflow}, {63'd0, got.ovf});
    end
    @(posedge clk); #1;
    chk("done_pulse_end", {62'd0, done, ready}, 64'd1);
  endtask

  initial begin
    int n, pulses;

    vecs[0] = '{32'h0000_0000, 32'h0000_0000, 64'h0000_0000_0000_0000, 1'b0};
    vecs[1] = '{32'h0000_0001, 32'h0000_0001, 64'h0000_0000_0000_0001, 1'b0};
    vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1};
    vecs[3] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b1};
    vecs[4] = '{32'h0000_FFFF, 32'h0001_0001, 64'h0000_0000_FFFF_FFFF, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF, 1'b0};
    vecs[6] = '{32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000, 1'b1};
    vecs[7] = '{32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F, 1'b0};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {60'd0, ready, busy, done, overflow}, 64'h8);
    chk("reset_product", product, 64'd0);
    @(negedge clk); rst = 1'b0;

    // Table-driven vectors with hard-coded expectations.
    foreach (vecs[i]) begin
      wait_ready();
      @(negedge clk);
      start = 1'b1; a = vecs[i].a; b = vecs[i].b;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(n);
      chk($sformatf("vec%0d_latency", i), 64'(n), 64'd32);
      chk($sformatf("vec%0d_product", i), product, vecs[i].prod);
      chk($sformatf("vec%0d_overflow", i), {63'd0, overflow}, {63'd0, vecs[i].ovf});
    end

    // Start held high through RUN, operands changed mid-run.
    wait_ready();
    @(negedge clk);
    start = 1'b1; a = 32'd3; b = 32'd5;
    @(posedge clk); #1;
    pulses = 0;
    for (int c = 1; c <= 32; c++) begin
      if (c == 5) begin a = 32'd7; b = 32'd9; end
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("hold_done_pulses", 64'(pulses), 64'd1);
    chk("hold_product", product, 64'd15);
    @(posedge clk); #1;
    chk("hold_ready_back", {62'd0, ready, done}, 64'd2);
    @(posedge clk); #1;
    chk("hold_reaccept", {63'd0, busy}, 64'd1);
    start = 1'b0;
    wait_done(n);
    chk("hold_second_product", product, 64'd63);

    // Asynchronous reset in the middle of a run.
    wait_ready();
    @(negedge clk);
    start = 1'b1; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_state", {60'd0, ready, busy, done, overflow}, 64'h8);
    chk("abort_product", product, 64'd0);
    @(negedge clk); rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("abort_no_done", 64'(pulses), 64'd0);
    run_op(32'd6, 32'd7);

    // Random back-to-back regression.
    for (int i = 0; i < 1000; i++) begin
      run_op($urandom, $urandom);
    end
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_seq_32.md
# mult_seq_32

Sequential 32x32 unsigned shift-and-add multiplier. It sits directly downstream of the 32-bit carry-lookahead adder and consumes it: a single CLA_32 instance performs one partial-product accumulation per cycle. The block produces a 64-bit product after a fixed 32-iteration run. It is the first multi-cycle arithmetic unit built on the adder and the basis for a later ALU multiply path.

## Interface
Parameters:
- none. Width is fixed at 32 by the CLA_32 datapath.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset; clears all state immediately.
- start  input  1  request a multiply; sampled only when `ready`=1.
- a  input  32  multiplicand (unsigned); captured on the accepted `start` edge.
- b  input  32  multiplier (unsigned); captured on the accepted `start` edge.
- ready  output  1  high in IDLE only.
- busy  output  1  high in RUN only.
- done  output  1  one-cycle pulse; high in DONE only.
- product  output  64  last completed result; holds until the next DONE.
- overflow  output  1  registered with `product`; equals |product[63:32] (result does not fit in 32 bits).

## Operation
- **Internal state:**
  - mcand[31:0]: multiplicand register.
  - acc[64:0]: hi = acc[63:32], lo = acc[31:0], with spare carry bit acc[64].
  - cnt[5:0]: iteration counter.
  - state: one of IDLE, RUN, DONE.
- **CLA_32 hookup:** a=acc[63:32], b=mcand, c_in=0. Its `s` and `c_out` are used; its `overflow` output is left unconnected.
- **IDLE:**
  - ready=1.
  - On an edge with start=1: mcand<=a, acc<={33'b0, b}, cnt<=0, go to RUN.
  - With start=0: remain in IDLE.
- **RUN (busy=1), each edge:**
  - If acc[0]=1: acc[63:0] <= {c_out, s, acc[31:1]}.
  - Else: acc[63:0] <= {1'b0, acc[63:32], acc[31:1]}.
  - cnt<=cnt+1.
  - When cnt==31 on that edge, go to DONE.
  - Effect: exactly 32 iterations. The carry out of each add becomes bit 63 after the shift, so no bit is lost. acc[64] stays 0; hi + mcand never exceeds 33 bits.
- **DONE:**
  - done=1.
  - On entry, i.e. on the same edge as the last iteration, product<=final acc[63:0] and overflow<=|final acc[63:32].
  - Next edge returns to IDLE unconditionally.
- **start handling:**
  - Ignored in RUN and DONE; no queueing.
  - a/b changes after acceptance have no effect on the running operation.
- **Reset:**
  - state=IDLE, ready=1, busy=0, done=0, product=0, overflow=0, mcand=0, acc=0, cnt=0.
  - Reset asserted mid-RUN aborts the operation. No done pulse occurs, and product keeps the reset value 0, not a partial result.
- **Arithmetic:** unsigned only. Maximum result 0xFFFFFFFE_00000001 fits in 64 bits, so there is no wrap.

## Timing
- **Start sampling:** start is sampled at edge E0 while ready=1; after E0, busy=1 and ready=0.
- **Iterations:** occur at edges E1..E32.
  - After E32: state=DONE, done=1, product/overflow valid.
  - After E33: IDLE, ready=1.
- **Latency:**
  - 32 cycles from the accepting edge to done high.
  - 33 cycles until the next start can be accepted.
  - Throughput: one multiply per 33 cycles.
- **Output timing:** product and overflow change only at the edge entering DONE and are stable for the whole done cycle and after it.
- **Combinational path:** the CLA_32 path (hi + mcand) must close within one clock. No other combinational path runs from inputs to outputs; all outputs are registers or decodes of state.
- **Reset timing:** asynchronous assert, synchronous-style release. Deassertion must meet recovery time to clk.

## Test plan
- **Zero and identity:** rst pulse, then start with a=0, b=0 -> done exactly 32 cycles after the accept edge, product=0, overflow=0. Then a=1, b=1 -> product=1.
- **Maximum operands:** a=0xFFFFFFFF, b=0xFFFFFFFF -> product=0xFFFFFFFE_00000001, overflow=1. Checks the carry captured from the CLA_32 c_out every iteration.
- **Overflow boundary:**
  - a=0x00010000, b=0x00010000 -> product=0x00000001_00000000, overflow=1.
  - a=0x0000FFFF, b=0x00010001 -> product=0x00000000_FFFFFFFF, overflow=0.
- **Ignored start:** start held high through RUN with a/b changed to 7/9 mid-run, original a=3, b=5 -> product=15. Exactly one done pulse; the next accept happens only after ready returns.
- **Reset mid-operation:** start a=0x12345678, b=0x9ABCDEF0, assert rst at cycle 10 of RUN -> immediately ready=1, busy=0, done=0, product=0, overflow=0, with no later done pulse. A following a=6, b=7 run -> product=42.
- **Random regression:** 1000 random a/b pairs back-to-back (start asserted as soon as ready) -> each product equals {32'b0,a}*{32'b0,b}, overflow matches the upper half, and each result takes 33 cycles.
